alu_issue_wb: RTL

- Operand-issue and writeback stage wrapped around the existing combinational 16-bit ALU (4-bit opcode: 0 add, 1 sub, 2 sll, 3 and).
- Decodes 16-bit instruction words and reads operands from an internal register file.
- Drives registered A/B/Opcode into the ALU, then writes the ALU result back one cycle later.
- Provides rd-to-rs/rt bypass, illegal-op and HALT handling, and a retired-instruction counter.

---
 rtl/alu_issue_wb_pkg.sv | 36 +++
 rtl/alu_issue_wb_if.sv | 33 +++
 rtl/alu.sv | 26 ++
 rtl/regfile_2r1w.sv | 37 +++
 rtl/alu_issue_wb.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/alu_issue_wb_pkg.sv
// Shared constants for the ALU issue/writeback stage: opcodes, instruction field
// positions and the opcode classification helper.
package alu_issue_wb_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned RegIdxW  = 4;
  localparam int unsigned OpW      = 4;

  localparam logic [OpW-1:0] OP_ADD  = 4'd0;
  localparam logic [OpW-1:0] OP_SUB  = 4'd1;
  localparam logic [OpW-1:0] OP_SLL  = 4'd2;
  localparam logic [OpW-1:0] OP_AND  = 4'd3;
  localparam logic [OpW-1:0] OP_HALT = 4'd15;

  localparam int unsigned OpMsb = 15;
  localparam int unsigned OpLsb = 12;
  localparam int unsigned RdMsb = 11;
  localparam int unsigned RdLsb = 8;
  localparam int unsigned RsMsb = 7;
  localparam int unsigned RsLsb = 4;
  localparam int unsigned RtMsb = 3;
  localparam int unsigned RtLsb = 0;

  typedef enum logic [1:0] {
    KindAlu,
    KindHalt,
    KindIllegal
  } op_kind_e;

  function automatic op_kind_e op_kind(input logic [OpW-1:0] op);
    if (op <= OP_AND) return KindAlu;
    if (op == OP_HALT) return KindHalt;
    return KindIllegal;
  endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction-issue handshake and writeback report of the ALU issue/writeback stage.
interface alu_issue_wb_if
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_instr;
  logic                 wb_valid;
  logic [RegIdxW-1:0]   wb_rd;
  logic [DATA_W-1:0]    wb_data;

  modport master (
    output in_valid,
    output in_instr,
    input  in_ready,
    input  wb_valid,
    input  wb_rd,
    input  wb_data
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready,
    output wb_valid,
    output wb_rd,
    output wb_data
  );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit ALU: add, sub, shift-left-logical, and. Other opcodes yield 0.
module alu
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OpW-1:0]    op_i,
  output logic [DATA_W-1:0] result_o
);

  localparam int unsigned ShW = $clog2(DATA_W);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLL:  result_o = a_i << b_i[ShW-1:0];
      OP_AND:  result_o = a_i & b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: two operand read ports plus a debug read port, one synchronous
// write port. With ZERO_REG set, r0 reads as zero and ignores writes.
module regfile_2r1w
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NREGS    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RegIdxW-1:0] ra_i,
  input  logic [RegIdxW-1:0] rb_i,
  input  logic [RegIdxW-1:0] rc_i,
  output logic [DATA_W-1:0]  ra_data_o,
  output logic [DATA_W-1:0]  rb_data_o,
  output logic [DATA_W-1:0]  rc_data_o,
  input  logic               we_i,
  input  logic [RegIdxW-1:0] wa_i,
  input  logic [DATA_W-1:0]  wd_i
);

  logic [DATA_W-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && !(ZERO_REG && (wa_i == '0))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ZERO_REG && (ra_i == '0)) ? '0 : mem_q[ra_i];
  assign rb_data_o = (ZERO_REG && (rb_i == '0)) ? '0 : mem_q[rb_i];
  assign rc_data_o = (ZERO_REG && (rc_i == '0)) ? '0 : mem_q[rc_i];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand issue and writeback stage around an external combinational ALU:
// decode, regfile read with EX-result bypass, writeback, HALT/illegal handling.
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned NREGS    = 16,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_wb_if.slave      bus,
  output logic [DATA_W-1:0]  alu_a_o,
  output logic [DATA_W-1:0]  alu_b_o,
  output logic [OpW-1:0]     alu_op_o,
  input  logic [DATA_W-1:0]  alu_result_i,
  output logic               illegal_op_o,
  output logic               halted_o,
  output logic [15:0]        retired_o,
  input  logic [RegIdxW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0]  dbg_data_o
);

  logic [OpW-1:0]     op;
  logic [RegIdxW-1:0] rd, rs, rt;
  logic [DATA_W-1:0]  rs_data, rt_data;

  logic [DATA_W-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OpW-1:0]     alu_op_q, alu_op_d;
  logic [RegIdxW-1:0] ex_rd_q, ex_rd_d;
  logic               ex_valid_q, ex_valid_d;
  logic               wb_valid_q, wb_valid_d;
  logic [RegIdxW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               illegal_q, illegal_d;
  logic               halted_q, halted_d;
  logic               halt_pending_q, halt_pending_d;
  logic [15:0]        retired_q, retired_d;

  op_kind_e ex_kind;
  logic     accept, ex_alu, byp_ok;

  assign op = bus.in_instr[OpMsb:OpLsb];
  assign rd = bus.in_instr[RdMsb:RdLsb];
  assign rs = bus.in_instr[RsMsb:RsLsb];
  assign rt = bus.in_instr[RtMsb:RtLsb];

  assign bus.in_ready = !rst && !halted_q && !halt_pending_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign ex_kind      = op_kind(alu_op_q);
  assign ex_alu       = ex_valid_q && (ex_kind == KindAlu);
  // The EX result is being written this edge, so the regfile copy is stale.
  assign byp_ok       = ex_alu && ((ex_rd_q != '0) || !ZERO_REG);

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_i     (rs),
    .rb_i     (rt),
    .rc_i     (dbg_addr_i),
    .ra_data_o(rs_data),
    .rb_data_o(rt_data),
    .rc_data_o(dbg_data_o),
    .we_i     (ex_alu),
    .wa_i     (ex_rd_q),
    .wd_i     (alu_result_i)
  );

  always_comb begin
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_op_d       = alu_op_q;
    ex_rd_d        = ex_rd_q;
    ex_valid_d     = accept;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    illegal_d      = 1'b0;
    halted_d       = halted_q;
    halt_pending_d = halt_pending_q;
    retired_d      = retired_q;

    if (accept) begin
      alu_a_d  = (byp_ok && (ex_rd_q == rs)) ? alu_result_i : rs_data;
      alu_b_d  = (byp_ok && (ex_rd_q == rt)) ? alu_result_i : rt_data;
      alu_op_d = op;
      ex_rd_d  = rd;
      if (op == OP_HALT) halt_pending_d = 1'b1;
    end

    if (ex_valid_q) begin
      case (ex_kind)
        KindAlu: begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_rd_q;
          wb_data_d  = alu_result_i;
          retired_d  = retired_q + 16'd1;
        end
        KindHalt: begin
          halted_d       = 1'b1;
          halt_pending_d = 1'b0;
          retired_d      = retired_q + 16'd1;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      ex_rd_q        <= '0;
      ex_valid_q     <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      illegal_q      <= 1'b0;
      halted_q       <= 1'b0;
      halt_pending_q <= 1'b0;
      retired_q      <= '0;
    end else begin
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_op_q       <= alu_op_d;
      ex_rd_q        <= ex_rd_d;
      ex_valid_q     <= ex_valid_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      illegal_q      <= illegal_d;
      halted_q       <= halted_d;
      halt_pending_q <= halt_pending_d;
      retired_q      <= retired_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign illegal_op_o = illegal_q;
  assign halted_o     = halted_q;
  assign retired_o    = retired_q;

endmodule
